// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared state encoding and default sizes for the divider scheduler
package div_sched_pkg;

    localparam int N_DEF = 4;
    localparam int R_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        SEN1,
        SEN2,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/div_sched_div.sv
// rtl/div_sched_div.sv - sequential restoring divider, two cycles per quotient bit
module div #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sen1,
    input  logic         sen2,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] q
);

    localparam int CW = $clog2(2 * N + 1);

    logic [N:0]    rem;
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          run;

    // sen1 loads operands and clears done; sen2 launches 2N steps (even = shift, odd = subtract)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem  <= '0;
            q    <= '0;
            dvs  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (sen1) begin
            rem  <= '0;
            q    <= dividend;
            dvs  <= divisor;
            done <= 1'b0;
            run  <= 1'b0;
        end else if (sen2) begin
            cnt <= CW'(2 * N);
            run <= 1'b1;
        end else if (run) begin
            if (!cnt[0]) begin
                rem <= {rem[N-1:0], q[N-1]};
                q   <= {q[N-2:0], 1'b0};
            end else if (rem >= {1'b0, dvs}) begin
                rem  <= rem - {1'b0, dvs};
                q[0] <= 1'b1;
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - round-robin scheduler sharing one sequential divider among R requesters
module div_sched
    import div_sched_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int R = R_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [R-1:0]   req_valid,
    input  logic [R*N-1:0] req_dividend,
    input  logic [R*N-1:0] req_divisor,
    output logic [R-1:0]   req_ready,
    output logic [R-1:0]   rsp_valid,
    output logic [N-1:0]   rsp_quotient,
    output logic           rsp_div_zero,
    output logic           busy
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    state_t        state, state_nx;
    logic [IW-1:0] last_grant, owner, win_idx;
    logic          win_found;
    logic [N-1:0]  win_a, win_b;
    logic [N-1:0]  op_a, op_b, q_cap, div_q;
    logic          div_zero, div_done, sen1, sen2;
    logic [R-1:0]  grant;
    int            rr_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        for (int i = 0; i < R; i++) begin
            rr_idx = (int'(last_grant) + 1 + i) % R;
            if (!win_found && req_valid[IW'(rr_idx)]) begin
                win_found = 1'b1;
                win_idx   = IW'(rr_idx);
            end
        end
    end

    assign win_a = req_dividend[win_idx*N +: N];
    assign win_b = req_divisor[win_idx*N +: N];

    always_comb begin
        state_nx = state;
        grant    = '0;
        sen1     = 1'b0;
        sen2     = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant[win_idx] = 1'b1;
                    state_nx       = (win_b == '0) ? RESP : SEN1;
                end
            end
            SEN1: begin
                sen1     = 1'b1;
                state_nx = SEN2;
            end
            SEN2: begin
                sen2     = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (div_done) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // grants are masked while reset is held so no handshake can be seen during reset
    assign req_ready = grant & {R{reset_n}};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant   <= IW'(R - 1);
            owner        <= '0;
            op_a         <= '0;
            op_b         <= '0;
            q_cap        <= '0;
            div_zero     <= 1'b0;
            rsp_valid    <= '0;
            rsp_quotient <= '0;
            rsp_div_zero <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= '0;
            if (state == IDLE && win_found) begin
                last_grant <= win_idx;
                owner      <= win_idx;
                op_a       <= win_a;
                op_b       <= win_b;
                div_zero   <= (win_b == '0);
                q_cap      <= '1;
            end
            if (state == WAIT && div_done) q_cap <= div_q;
            if (state == RESP) begin
                rsp_valid    <= R'(1) << owner;
                rsp_quotient <= q_cap;
                rsp_div_zero <= div_zero;
            end
        end
    end

    div #(.N(N)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .sen1     (sen1),
        .sen2     (sen2),
        .dividend (op_a),
        .divisor  (op_b),
        .done     (div_done),
        .q        (div_q)
    );

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - randomized self-checking bench for div_sched against a transaction-level model
module tb_div_sched;

    localparam int N = 4;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_dividend;
    logic [R*N-1:0] req_divisor;
    logic [R-1:0]   req_ready;
    logic [R-1:0]   rsp_valid;
    logic [N-1:0]   rsp_quotient;
    logic           rsp_div_zero;
    logic           busy;

    div_sched #(.N(N), .R(R)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .rsp_div_zero (rsp_div_zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int sen1_cnt = 0;
    int rsp_cnt  = 0;
    int model_last;
    logic [N-1:0] op_a [R];
    logic [N-1:0] op_b [R];

    always @(posedge clk) begin
        if (dut.u_div.sen1) sen1_cnt <= sen1_cnt + 1;
        if (rsp_valid != '0) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < R; i++) begin
            req_dividend[i*N +: N] = op_a[i];
            req_divisor[i*N +: N]  = op_b[i];
        end
    endtask

    function automatic int next_rr(input logic [R-1:0] mask);
        for (int i = 1; i <= R; i++)
            if (mask[(model_last + i) % R]) return (model_last + i) % R;
        return -1;
    endfunction

    // Hold every requester in mask valid and serve n grants, checking order, latency and result.
    task automatic serve(input logic [R-1:0] mask, input int n);
        int exp_idx, lat, waited, exp_lat;
        logic [N-1:0] a, b;
        req_valid = mask;
        drive_ops();
        #1;
        for (int k = 0; k < n; k++) begin
            exp_idx = next_rr(mask);
            waited  = 0;
            while (req_ready == '0 && waited < 50) begin
                @(posedge clk); #1;
                waited++;
            end
            check("grant", int'(req_ready), 1 << exp_idx);
            a          = op_a[exp_idx];
            b          = op_b[exp_idx];
            model_last = exp_idx;
            @(posedge clk); #1;
            op_a[exp_idx] = N'($urandom);
            op_b[exp_idx] = N'($urandom);
            drive_ops();
            if (k == n - 1) req_valid = '0;
            lat = 0;
            while (rsp_valid == '0 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            exp_lat = (b == '0) ? 1 : 2 * N + 4;
            check("latency", lat, exp_lat);
            check("rsp_valid", int'(rsp_valid), 1 << exp_idx);
            check("quotient", int'(rsp_quotient), (b == '0) ? (1 << N) - 1 : int'(a) / int'(b));
            check("div_zero", int'(rsp_div_zero), int'(b == '0));
        end
    endtask

    initial begin
        int s0, r0;
        reset_n      = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        for (int i = 0; i < R; i++) begin
            op_a[i] = N'(4 * i + 5);
            op_b[i] = N'(i + 1);
        end
        #2 reset_n = 1'b0;
        req_valid = '1;
        drive_ops();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_quotient", int'(rsp_quotient), 0);
        check("rst_div_zero", int'(rsp_div_zero), 0);
        check("rst_busy", int'(busy), 0);
        reset_n    = 1'b1;
        model_last = R - 1;

        serve(4'hF, 5);

        op_a[2] = 4'd13; op_b[2] = 4'd3;
        serve(4'b0100, 1);

        op_a[1] = 4'd9; op_b[1] = 4'd0;
        s0 = sen1_cnt;
        serve(4'b0010, 1);
        check("sen1_on_zero_div", sen1_cnt - s0, 0);

        op_a[0] = 4'd15; op_b[0] = 4'd1;
        serve(4'b0001, 1);
        op_a[3] = 4'd0; op_b[3] = 4'd7;
        serve(4'b1000, 1);

        op_a[0] = 4'd13; op_b[0] = 4'd3;
        req_valid = 4'b0001;
        drive_ops();
        #1;
        s0 = 0;
        while (req_ready == '0 && s0 < 50) begin
            @(posedge clk); #1;
            s0++;
        end
        check("abort_grant", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        r0 = rsp_cnt;
        reset_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk); #1;
        reset_n    = 1'b1;
        model_last = R - 1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_rsp", rsp_cnt - r0, 0);
        check("abort_idle", int'(busy), 0);
        op_a[1] = 4'd6; op_b[1] = 4'd2;
        serve(4'b0010, 1);

        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < R; i++) begin
                op_a[i] = N'($urandom);
                op_b[i] = N'($urandom_range(0, 15));
            end
            serve(R'($urandom_range(1, 15)), $urandom_range(1, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
